reg_file_ctrl: RTL
==================

Name: reg_file_ctrl

Overview:
- Initiator for the 8-bit register file.
- Accepts one-at-a-time register commands (READ, WRITE, MOVE, SWAP) over a valid/ready port.
- Sequences the register file's ADDR/CE/DATA_IN port and accounts for its one-cycle registered read latency.
- Returns a single-cycle response pulse.
- Sits between the CPU control unit and the register file, so the control unit never tracks read timing itself.

Parameters:
- ADDR_W, 4, width of register address.
- DATA_W, 8, register data width.
- NUM_REGS, 4, number of implemented registers; valid addresses are 0..NUM_REGS-1.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous reset, active-high.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  controller idle and able to accept a command.
- CMD_OP  in  2  0=READ, 1=WRITE, 2=MOVE (RB<=RA), 3=SWAP (RA<->RB).
- CMD_RA  in  ADDR_W  first register.
- CMD_RB  in  ADDR_W  second register (MOVE/SWAP only).
- CMD_DATA  in  DATA_W  write data (WRITE only).
- RSP_VALID  out  1  one-cycle completion pulse.
- RSP_DATA  out  DATA_W  READ: value read; WRITE: value written; MOVE: value moved; SWAP: original RA value.
- RSP_ERR  out  1  error flag, valid with RSP_VALID (0 unless the optional feature is enabled).
- RF_ADDR  out  ADDR_W  register file address.
- RF_CE  out  1  register file write enable.
- RF_DATA_IN  out  DATA_W  register file write data.
- RF_DATA_OUT  in  DATA_W  register file registered read data; holds the value at the address driven in the previous cycle.

Behaviour:
- FSM states: IDLE, RD_A, CAP_A, RD_B, CAP_B, WR_A, WR_B, RESP.
- CMD_READY=1 only in IDLE. A command is accepted on the edge where CMD_VALID&&CMD_READY. At that edge OP/RA/RB/DATA are latched into command registers.
- State paths after accept:
  - READ: RD_A -> CAP_A -> RESP -> IDLE.
  - WRITE: WR_A -> RESP -> IDLE.
  - MOVE: RD_A -> CAP_A -> WR_B -> RESP -> IDLE.
  - SWAP: RD_A -> CAP_A -> RD_B -> CAP_B -> WR_A -> WR_B -> RESP -> IDLE.
- Per-state drive:
  - RD_A/CAP_A: RF_ADDR=RA. Holding the address in CAP_A keeps RF_DATA_OUT stable.
  - RD_B/CAP_B: RF_ADDR=RB.
  - CAP_A captures RF_DATA_OUT into tmpA; CAP_B captures it into tmpB.
  - WR_A: RF_ADDR=RA, RF_CE=1, RF_DATA_IN = CMD_DATA (WRITE) or tmpB (SWAP).
  - WR_B: RF_ADDR=RB, RF_CE=1, RF_DATA_IN=tmpA.
  - IDLE and RESP: RF_ADDR=0, RF_CE=0, RF_DATA_IN=0.
- Latency from accept edge to RSP_VALID high: READ 3 cycles, WRITE 2, MOVE 4, SWAP 7.
- RSP_VALID is high for exactly one cycle (the RESP state). There is no response backpressure.
- RSP_DATA holds its last value until the next RESP.
- MOVE/SWAP with RA==RB: runs the normal sequence; the register is unchanged.
- Reset:
  - Outputs during reset: CMD_READY=0 while RST=1; RSP_VALID=0, RSP_DATA=0, RSP_ERR=0; RF_ADDR=0, RF_CE=0, RF_DATA_IN=0.
  - Reset clears state to IDLE and clears tmpA, tmpB and the command registers.
  - RF_CE is combinationally gated by !RST, so no register write occurs in any cycle where RST=1, including reset asserted mid-SWAP.
  - A SWAP aborted after WR_A leaves RA written and RB old; this is accepted behaviour.
- A CMD_VALID held while busy is ignored until IDLE; the bench must hold the command stable.

Optional Feature:
- Macro: REG_FILE_CTRL_RANGE_CHECK_EN.
- Defined:
  - In IDLE, an accepted command with RA>=NUM_REGS (any op), or RB>=NUM_REGS (MOVE/SWAP), goes directly to RESP.
  - RSP_ERR=1 and RSP_DATA=0.
  - No RF access and RF_CE never asserted; latency 1 cycle.
- Undefined:
  - No check; addresses are passed to RF unchanged.
  - RSP_ERR is tied to 0.

Decomposition:
- Package reg_file_ctrl_pkg holds:
  - the op enum (OP_READ, OP_WRITE, OP_MOVE, OP_SWAP);
  - the state enum;
  - default ADDR_W/DATA_W/NUM_REGS constants.
- No sub-module: a single FSM plus datapath registers is natural.
- The bench instantiates the existing register file alongside the controller.

Test Plan:
- After reset, WRITE RA=2 DATA=0xA5 -> RF_CE high for one cycle with RF_ADDR=2; RSP_VALID 2 cycles after accept with RSP_DATA=0xA5. A following READ RA=2 -> RSP_DATA=0xA5 3 cycles after accept.
- WRITE r0=0x11, WRITE r1=0x22, SWAP RA=0 RB=1 -> RSP_VALID 7 cycles after accept with RSP_DATA=0x11. Subsequent reads return r0=0x22, r1=0x11.
- WRITE r3=0x5C, MOVE RA=3 RB=1 -> RSP_DATA=0x5C; read r1=0x5C, r3 still 0x5C.
- SWAP RA=2 RB=2 with r2=0x7E -> completes in 7 cycles; r2 still 0x7E.
- Assert RST in the WR_A cycle of a SWAP -> RF_CE=0 that cycle; CMD_READY=1 the cycle after RST deasserts; r0/r1 unchanged.
- With REG_FILE_CTRL_RANGE_CHECK_EN, READ RA=5 -> RSP_VALID 1 cycle after accept, RSP_ERR=1, RSP_DATA=0, RF_CE never high.

Source files
------------

// File: rtl/reg_file_ctrl_pkg.sv
// reg_file_ctrl shared types: command opcodes, controller states and
// default geometry of the 8-bit register file.
package reg_file_ctrl_pkg;

    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_REGS = 4;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_MOVE  = 2'd2,
        OP_SWAP  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        CAP_A,
        RD_B,
        CAP_B,
        WR_A,
        WR_B,
        RESP
    } state_e;

    function automatic int op_latency(input op_e op);
        unique case (op)
            OP_READ:  return 3;
            OP_WRITE: return 2;
            OP_MOVE:  return 4;
            default:  return 7;
        endcase
    endfunction

endpackage

// File: rtl/reg_file_ctrl_if.sv
// Command/response port between the CPU control unit (master) and
// reg_file_ctrl (slave).
interface reg_file_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              CMD_VALID;
    logic              CMD_READY;
    logic [1:0]        CMD_OP;
    logic [ADDR_W-1:0] CMD_RA;
    logic [ADDR_W-1:0] CMD_RB;
    logic [DATA_W-1:0] CMD_DATA;
    logic              RSP_VALID;
    logic [DATA_W-1:0] RSP_DATA;
    logic              RSP_ERR;

    modport master (
        output CMD_VALID, CMD_OP, CMD_RA, CMD_RB, CMD_DATA,
        input  CMD_READY, RSP_VALID, RSP_DATA, RSP_ERR
    );

    modport slave (
        input  CMD_VALID, CMD_OP, CMD_RA, CMD_RB, CMD_DATA,
        output CMD_READY, RSP_VALID, RSP_DATA, RSP_ERR
    );
endinterface

// File: rtl/reg_file_ctrl.sv
// Register file initiator: sequences READ/WRITE/MOVE/SWAP over the RF port.
// Define REG_FILE_CTRL_RANGE_CHECK_EN to reject out-of-range addresses.
module reg_file_ctrl
    import reg_file_ctrl_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic              CLK,
    input  logic              RST,
    reg_file_ctrl_if.slave    bus,
    output logic [ADDR_W-1:0] RF_ADDR,
    output logic              RF_CE,
    output logic [DATA_W-1:0] RF_DATA_IN,
    input  logic [DATA_W-1:0] RF_DATA_OUT
);

`ifdef REG_FILE_CTRL_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

    state_e            state, nxt;
    op_e               cmd_op;
    logic [ADDR_W-1:0] cmd_ra, cmd_rb;
    logic [DATA_W-1:0] cmd_data;
    logic [DATA_W-1:0] tmp_a, tmp_b;
    logic [DATA_W-1:0] rsp_q, rsp_d;
    logic              err_q, err_d, rsp_ld;
    logic              range_err;
    op_e               op_in;
    logic [ADDR_W-1:0] addr_c;
    logic              ce_c;
    logic [DATA_W-1:0] din_c;

    assign op_in = op_e'(bus.CMD_OP);

    assign range_err = RANGE_CHK &&
        (({1'b0, bus.CMD_RA} >= NREGS) ||
         ((op_in == OP_MOVE || op_in == OP_SWAP) &&
          ({1'b0, bus.CMD_RB} >= NREGS)));

    always_comb begin
        nxt    = state;
        rsp_ld = 1'b0;
        rsp_d  = rsp_q;
        err_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.CMD_VALID) begin
                    if (range_err) begin
                        nxt    = RESP;
                        rsp_ld = 1'b1;
                        rsp_d  = '0;
                        err_d  = 1'b1;
                    end else if (op_in == OP_WRITE) begin
                        nxt = WR_A;
                    end else begin
                        nxt = RD_A;
                    end
                end
            end
            RD_A:  nxt = CAP_A;
            CAP_A: begin
                unique case (cmd_op)
                    OP_MOVE: nxt = WR_B;
                    OP_SWAP: nxt = RD_B;
                    default: begin
                        nxt    = RESP;
                        rsp_ld = 1'b1;
                        rsp_d  = RF_DATA_OUT;
                    end
                endcase
            end
            RD_B:  nxt = CAP_B;
            CAP_B: nxt = WR_A;
            WR_A: begin
                if (cmd_op == OP_SWAP) begin
                    nxt = WR_B;
                end else begin
                    nxt    = RESP;
                    rsp_ld = 1'b1;
                    rsp_d  = cmd_data;
                end
            end
            WR_B: begin
                nxt    = RESP;
                rsp_ld = 1'b1;
                rsp_d  = tmp_a;
            end
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        addr_c = '0;
        ce_c   = 1'b0;
        din_c  = '0;
        unique case (state)
            RD_A, CAP_A: addr_c = cmd_ra;
            RD_B, CAP_B: addr_c = cmd_rb;
            WR_A: begin
                addr_c = cmd_ra;
                ce_c   = 1'b1;
                din_c  = (cmd_op == OP_SWAP) ? tmp_b : cmd_data;
            end
            WR_B: begin
                addr_c = cmd_rb;
                ce_c   = 1'b1;
                din_c  = tmp_a;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            cmd_op   <= OP_READ;
            cmd_ra   <= '0;
            cmd_rb   <= '0;
            cmd_data <= '0;
            tmp_a    <= '0;
            tmp_b    <= '0;
            rsp_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && bus.CMD_VALID) begin
                cmd_op   <= op_in;
                cmd_ra   <= bus.CMD_RA;
                cmd_rb   <= bus.CMD_RB;
                cmd_data <= bus.CMD_DATA;
            end
            if (state == CAP_A) tmp_a <= RF_DATA_OUT;
            if (state == CAP_B) tmp_b <= RF_DATA_OUT;
            if (rsp_ld) begin
                rsp_q <= rsp_d;
                err_q <= err_d;
            end
        end
    end

    // Reset masks every output at once, so a write cannot slip out mid-SWAP.
    assign bus.CMD_READY = (state == IDLE) && !RST;
    assign bus.RSP_VALID = (state == RESP) && !RST;
    assign bus.RSP_DATA  = RST ? '0 : rsp_q;
    assign bus.RSP_ERR   = err_q && !RST;
    assign RF_ADDR       = RST ? '0 : addr_c;
    assign RF_CE         = ce_c && !RST;
    assign RF_DATA_IN    = RST ? '0 : din_c;

endmodule
